// File: rtl/scard_iso7816_uart.sv
// scard_iso7816_uart
//   Character-level ISO 7816-3 T=0 half-duplex transceiver for the smartcard
//   I/O contact. It runs on the card clock, so all ETU timing is counted in
//   card clocks. It handles start/parity framing, guard time, the error-signal
//   handshake and automatic retransmission.
//
// Ports
//   clk, rstnin        card clock; synchronous active-low reset
//   tx_data/valid/ready  character handshake toward the card
//   tx_done / tx_err   one-cycle pulses: sent cleanly / retries exhausted
//   rx_data/rx_valid   received character; rx_data is held until the next rx_valid
//   rx_parity_err      one-cycle pulse: bad parity, error signal was issued
//   io_in              raw card_io pad level (asynchronous)
//   io_drive_low       1 = pull card_io low, 0 = release
//   busy               FSM not in IDLE
//
// Optional feature: define SCARD_INVERSE_CONV_EN to add input conv_inverse.
//   conv_inverse is sampled in IDLE. When it is 1, the block uses the inverse
//   convention: data bits are sent MSB-first and inverted.
module scard_iso7816_uart #(
  parameter int ETU_CYCLES = 372,  // 8..4095
  parameter int GUARD_ETU  = 2,
  parameter int MAX_RETRY  = 3     // <= 15
) (
  input  logic       clk,
  input  logic       rstnin,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       tx_done,
  output logic       tx_err,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       rx_parity_err,
  input  logic       io_in,
  output logic       io_drive_low,
  output logic       busy
`ifdef SCARD_INVERSE_CONV_EN
  ,
  input  logic       conv_inverse
`endif
);

  typedef enum logic [2:0] {
    IDLE, TX_BITS, TX_CHK, TX_GUARD, RX_START, RX_BITS, RX_ERRSIG, RX_GUARD
  } state_e;

  localparam logic [11:0] ETU_LAST  = 12'(ETU_CYCLES - 1);
  localparam logic [11:0] ETU_HALF  = 12'(ETU_CYCLES / 2);
  localparam logic [4:0]  TX_END    = 5'(10 + GUARD_ETU);
  localparam logic [3:0]  RETRY_MAX = 4'(MAX_RETRY);

  state_e      state_q, state_d;
  logic [11:0] etu_q, etu_d, etu_nx;
  logic [4:0]  bit_idx_q, bit_idx_d, bit_nx;
  logic [7:0]  tx_sh_q, tx_sh_d, rx_sh_q, rx_sh_d, rx_data_q, rx_data_d;
  logic [3:0]  retry_q, retry_d;
  logic        par_q, par_d, inv_q, inv_d;
  logic        rtx_q, rtx_d, wait_hi_q, wait_hi_d;
  logic        drive_q, drive_d, rdy_q, rdy_d, busy_q, busy_d;
  logic        tx_done_q, tx_done_d, tx_err_q, tx_err_d;
  logic        rx_valid_q, rx_valid_d, rx_perr_q, rx_perr_d;
  logic        io_s1_q, io_s1_d, io_sync_q, io_sync_d, io_prev_q, io_prev_d;
  logic        fall, etu_wrap;

  // Line level for TX bit slot idx: 0 = start, 1..8 = data, 9 = parity.
  // The parity slot always carries ^d. Inverting all 8 data bits does not
  // change their XOR, so the line has even parity in both conventions.
  function automatic logic tx_line(input logic [7:0] d, input logic [4:0] idx,
                                   input logic inv);
    logic [2:0] k;
    tx_line = 1'b0;
    k = 3'(idx - 5'd1);
    if (idx >= 5'd1 && idx <= 5'd8) tx_line = inv ? ~d[3'd7 - k] : d[k];
    else if (idx == 5'd9)           tx_line = ^d;
  endfunction

  assign fall     = io_prev_q & ~io_sync_q;
  assign etu_wrap = (etu_q == ETU_LAST);
  assign etu_nx   = etu_wrap ? 12'd0 : etu_q + 12'd1;
  assign bit_nx   = bit_idx_q + {4'd0, etu_wrap};

  always_comb begin
    state_d    = state_q;
    etu_d      = etu_nx;
    bit_idx_d  = bit_nx;
    tx_sh_d    = tx_sh_q;
    rx_sh_d    = rx_sh_q;
    rx_data_d  = rx_data_q;
    retry_d    = retry_q;
    par_d      = par_q;
    inv_d      = inv_q;
    rtx_d      = rtx_q;
    wait_hi_d  = wait_hi_q;
    drive_d    = 1'b0;
    tx_done_d  = 1'b0;
    tx_err_d   = 1'b0;
    rx_valid_d = 1'b0;
    rx_perr_d  = 1'b0;
    io_s1_d    = io_in;
    io_sync_d  = io_s1_q;
    io_prev_d  = io_sync_q;
    case (state_q)
      IDLE: begin
        etu_d     = 12'd0;
        bit_idx_d = 5'd0;
`ifdef SCARD_INVERSE_CONV_EN
        inv_d = conv_inverse;
`else
        inv_d = 1'b0;
`endif
        if (fall) begin
          // The fall is seen one cycle late, so time starts at 1.
          state_d = RX_START;
          etu_d   = 12'd1;
          par_d   = 1'b0;
        end else if (tx_valid && tx_ready) begin
          state_d = TX_BITS;
          tx_sh_d = tx_data;
          drive_d = 1'b1;  // start bit
        end
      end
      TX_BITS: begin
        if (bit_nx == 5'd10) state_d = TX_CHK;
        else drive_d = ~tx_line(tx_sh_q, bit_nx, inv_q);
      end
      TX_CHK: begin
        if (bit_nx == 5'd11) begin
          state_d = TX_GUARD;
          rtx_d   = 1'b0;
          if (io_sync_q) begin
            tx_done_d = 1'b1;
            retry_d   = 4'd0;
          end else if (retry_q < RETRY_MAX) begin
            retry_d   = retry_q + 4'd1;
            rtx_d     = 1'b1;
            wait_hi_d = 1'b1;
          end else begin
            tx_err_d = 1'b1;
            retry_d  = 4'd0;
          end
        end
      end
      TX_GUARD: begin
        if (rtx_q) begin
          // Retry: hold the counters at zero while the card holds the line
          // low, then wait 2 ETU and resend from the start bit.
          if (wait_hi_q) begin
            etu_d     = 12'd0;
            bit_idx_d = 5'd0;
            if (io_sync_q) wait_hi_d = 1'b0;
          end else if (bit_nx == 5'd2) begin
            state_d   = TX_BITS;
            etu_d     = 12'd0;
            bit_idx_d = 5'd0;
            rtx_d     = 1'b0;
            drive_d   = 1'b1;
          end
        end else if (bit_nx == TX_END) begin
          state_d = IDLE;
        end
      end
      RX_START: begin
        if (etu_nx == ETU_HALF) state_d = io_sync_q ? IDLE : RX_BITS;
      end
      RX_BITS: begin
        if (etu_nx == ETU_HALF) begin
          if (bit_nx == 5'd9) begin
            if ((par_q ^ io_sync_q) == 1'b0) begin
              rx_data_d  = rx_sh_q;
              rx_valid_d = 1'b1;
              state_d    = RX_GUARD;
            end else begin
              state_d = RX_ERRSIG;
            end
          end else begin
            par_d   = par_q ^ io_sync_q;
            rx_sh_d = inv_q ? {rx_sh_q[6:0], ~io_sync_q} : {io_sync_q, rx_sh_q[7:1]};
          end
        end
      end
      RX_ERRSIG: begin
        drive_d = drive_q;
        if (etu_nx == ETU_HALF) begin
          if (bit_nx == 5'd10) drive_d = 1'b1;
          else if (bit_nx == 5'd11) begin
            drive_d   = 1'b0;
            rx_perr_d = 1'b1;
            state_d   = RX_GUARD;
          end
        end
      end
      RX_GUARD: begin
        if (bit_nx == 5'd12) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    rdy_d  = (state_d == IDLE);
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (!rstnin) begin
      state_q    <= IDLE;
      etu_q      <= 12'd0;
      bit_idx_q  <= 5'd0;
      tx_sh_q    <= 8'h00;
      rx_sh_q    <= 8'h00;
      rx_data_q  <= 8'h00;
      retry_q    <= 4'd0;
      par_q      <= 1'b0;
      inv_q      <= 1'b0;
      rtx_q      <= 1'b0;
      wait_hi_q  <= 1'b0;
      drive_q    <= 1'b0;
      rdy_q      <= 1'b0;
      busy_q     <= 1'b0;
      tx_done_q  <= 1'b0;
      tx_err_q   <= 1'b0;
      rx_valid_q <= 1'b0;
      rx_perr_q  <= 1'b0;
      io_s1_q    <= 1'b1;
      io_sync_q  <= 1'b1;
      io_prev_q  <= 1'b1;
    end else begin
      state_q    <= state_d;
      etu_q      <= etu_d;
      bit_idx_q  <= bit_idx_d;
      tx_sh_q    <= tx_sh_d;
      rx_sh_q    <= rx_sh_d;
      rx_data_q  <= rx_data_d;
      retry_q    <= retry_d;
      par_q      <= par_d;
      inv_q      <= inv_d;
      rtx_q      <= rtx_d;
      wait_hi_q  <= wait_hi_d;
      drive_q    <= drive_d;
      rdy_q      <= rdy_d;
      busy_q     <= busy_d;
      tx_done_q  <= tx_done_d;
      tx_err_q   <= tx_err_d;
      rx_valid_q <= rx_valid_d;
      rx_perr_q  <= rx_perr_d;
      io_s1_q    <= io_s1_d;
      io_sync_q  <= io_sync_d;
      io_prev_q  <= io_prev_d;
    end
  end

  // A fall seen in IDLE takes priority over a new TX character.
  assign tx_ready      = rdy_q & ~fall;
  assign tx_done       = tx_done_q;
  assign tx_err        = tx_err_q;
  assign rx_data       = rx_data_q;
  assign rx_valid      = rx_valid_q;
  assign rx_parity_err = rx_perr_q;
  assign io_drive_low  = drive_q;
  assign busy          = busy_q;

endmodule

// File: tb/tb_scard_iso7816_uart.sv
module tb_scard_iso7816_uart;
  localparam int ETU = 16;

  logic       clk = 1'b0;
  logic       rstnin = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic       tx_valid = 1'b0;
  logic       tx_ready, tx_done, tx_err, rx_valid, rx_parity_err;
  logic [7:0] rx_data;
  logic       io_drive_low, busy;
  logic       card_low = 1'b0;
  logic       io_in;

  // Open-drain wired-AND: the card or the DUT can pull the line low.
  assign io_in = ~card_low & ~io_drive_low;

  int n_vec = 0;
  int n_err = 0;

  scard_iso7816_uart #(.ETU_CYCLES(ETU), .GUARD_ETU(2), .MAX_RETRY(3)) dut (
    .clk(clk), .rstnin(rstnin),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .tx_done(tx_done), .tx_err(tx_err),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_parity_err(rx_parity_err),
    .io_in(io_in), .io_drive_low(io_drive_low), .busy(busy)
`ifdef SCARD_INVERSE_CONV_EN
    , .conv_inverse(1'b0)
`endif
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rstnin = 1'b0;
    repeat (3) tick();
    n_vec++;
    if ({tx_ready, tx_done, tx_err, rx_valid, rx_parity_err, io_drive_low, busy} !== 7'b0) begin
      n_err++;
      $display("FAIL reset_outs got=%b want=0000000",
               {tx_ready, tx_done, tx_err, rx_valid, rx_parity_err, io_drive_low, busy});
    end
    n_vec++;
    if (rx_data !== 8'h00) begin n_err++; $display("FAIL reset_rx_data got=%h want=00", rx_data); end
    rstnin = 1'b1;
    tick();
    n_vec++;
    if (tx_ready !== 1'b1) begin n_err++; $display("FAIL reset_ready got=%b want=1", tx_ready); end
  endtask

  // TX 8'h3B with a silent card: check the drive pattern and the
  // tx_done / tx_ready timing relative to the first start-bit cycle.
  task automatic test_tx_3b(input string tag);
    logic [9:0] exp_drv;
    int done_t, rdy_t, ndone, nerr;
    exp_drv = 10'b0110001001;  // bit n -> index n: 1,0,0,1,0,0,0,1,1,0
    done_t = -1; rdy_t = -1; ndone = 0; nerr = 0;
    n_vec++;
    if (tx_ready !== 1'b1) begin n_err++; $display("FAIL %s ready_pre got=%b want=1", tag, tx_ready); end
    tx_data = 8'h3B; tx_valid = 1'b1;
    tick();
    tx_valid = 1'b0; tx_data = 8'hFF;
    for (int t = 0; t < 260 && rdy_t < 0; t++) begin
      if (t < 192) begin
        n_vec++;
        if (io_drive_low !== ((t < 160) ? exp_drv[t / ETU] : 1'b0)) begin
          n_err++;
          $display("FAIL %s drive t=%0d got=%b want=%b", tag, t, io_drive_low,
                   (t < 160) ? exp_drv[t / ETU] : 1'b0);
        end
      end
      if (tx_done) begin ndone++; if (done_t < 0) done_t = t; end
      if (tx_err) nerr++;
      if (tx_ready && rdy_t < 0) rdy_t = t;
      tick();
    end
    n_vec++;
    if (done_t != 176 || ndone != 1) begin
      n_err++; $display("FAIL %s tx_done t=%0d n=%0d want t=176 n=1", tag, done_t, ndone);
    end
    n_vec++;
    if (rdy_t != 192) begin n_err++; $display("FAIL %s ready_t got=%0d want=192", tag, rdy_t); end
    n_vec++;
    if (nerr != 0) begin n_err++; $display("FAIL %s tx_err n=%0d want=0", tag, nerr); end
  endtask

  // The card sends d with parity bit p. The fall is seen at cycle 2, so DUT
  // time is cycle-2. The error signal covers 10.5..11.5 ETU (cycles 170..185)
  // and busy drops at 12 ETU (cycle 194).
  task automatic test_rx(input logic [7:0] d, input logic p, input string tag);
    logic [9:0] bits;
    logic [7:0] got, old;
    int nval, nperr, ndrv, drv_first, perr_t, idle_t;
    bits = {p, d, 1'b0};
    old = rx_data; got = 8'h00;
    nval = 0; nperr = 0; ndrv = 0; drv_first = -1; perr_t = -1; idle_t = -1;
    for (int t = 0; t < 260 && idle_t < 0; t++) begin
      card_low = (t < 160) ? ~bits[t / ETU] : 1'b0;
      if (rx_valid) begin nval++; got = rx_data; end
      if (rx_parity_err) begin nperr++; if (perr_t < 0) perr_t = t; end
      if (io_drive_low) begin ndrv++; if (drv_first < 0) drv_first = t; end
      if (t > 20 && !busy) idle_t = t;
      tick();
    end
    card_low = 1'b0;
    n_vec++;
    if (idle_t != 194) begin n_err++; $display("FAIL %s idle_t got=%0d want=194", tag, idle_t); end
    if (^{d, p} == 1'b0) begin
      n_vec++;
      if (nval != 1 || got !== d) begin
        n_err++; $display("FAIL %s rx_valid n=%0d data=%h want n=1 data=%h", tag, nval, got, d);
      end
      n_vec++;
      if (ndrv != 0 || nperr != 0) begin
        n_err++; $display("FAIL %s quiet drv=%0d perr=%0d want 0 0", tag, ndrv, nperr);
      end
    end else begin
      n_vec++;
      if (nval != 0) begin n_err++; $display("FAIL %s rx_valid n=%0d want=0", tag, nval); end
      n_vec++;
      if (ndrv != 16 || drv_first != 170) begin
        n_err++; $display("FAIL %s errsig len=%0d start=%0d want 16 170", tag, ndrv, drv_first);
      end
      n_vec++;
      if (nperr != 1 || perr_t != 186) begin
        n_err++; $display("FAIL %s perr n=%0d t=%0d want 1 186", tag, nperr, perr_t);
      end
      n_vec++;
      if (rx_data !== old) begin n_err++; $display("FAIL %s rx_data_held got=%h want=%h", tag, rx_data, old); end
    end
  endtask

  // A 7-cycle low glitch: fall at cycle 2, busy from cycle 3, recheck at
  // ETU/2 sees a high line, back to IDLE at cycle 10.
  task automatic test_glitch();
    int first_busy, idle_t, npulse;
    logic rdy2;
    first_busy = -1; idle_t = -1; npulse = 0; rdy2 = 1'bx;
    for (int t = 0; t < 40; t++) begin
      card_low = (t < 7);
      if (t == 2) rdy2 = tx_ready;
      if (busy && first_busy < 0) first_busy = t;
      if (!busy && first_busy >= 0 && idle_t < 0) idle_t = t;
      if (rx_valid || rx_parity_err || io_drive_low) npulse++;
      tick();
    end
    card_low = 1'b0;
    n_vec++;
    if (rdy2 !== 1'b0) begin n_err++; $display("FAIL glitch ready_on_fall got=%b want=0", rdy2); end
    n_vec++;
    if (first_busy != 3 || idle_t != 10) begin
      n_err++; $display("FAIL glitch busy start=%0d idle=%0d want 3 10", first_busy, idle_t);
    end
    n_vec++;
    if (npulse != 0) begin n_err++; $display("FAIL glitch pulses got=%0d want=0", npulse); end
  endtask

  // The card pulls the line low at 10.5..11.5 ETU of every character.
  task automatic test_retry();
    int nstart, cs, nerr, ndone, idle_t;
    logic act, prev_drv;
    nstart = 0; cs = 0; nerr = 0; ndone = 0; idle_t = -1; act = 1'b0; prev_drv = 1'b0;
    tx_data = 8'h55; tx_valid = 1'b1;
    tick();
    tx_valid = 1'b0;
    for (int t = 0; t < 1500 && idle_t < 0; t++) begin
      if (io_drive_low && !prev_drv && !act) begin act = 1'b1; cs = t; nstart++; end
      prev_drv = io_drive_low;
      card_low = act && (t - cs >= 168) && (t - cs < 184);
      if (act && (t - cs >= 184)) act = 1'b0;
      if (tx_err) nerr++;
      if (tx_done) ndone++;
      if (nerr > 0 && !busy) idle_t = t;
      tick();
    end
    card_low = 1'b0;
    n_vec++;
    if (idle_t < 0) begin n_err++; $display("FAIL retry timeout got=no_idle want=idle"); end
    n_vec++;
    if (nstart != 4) begin n_err++; $display("FAIL retry starts got=%0d want=4", nstart); end
    n_vec++;
    if (nerr != 1 || ndone != 0) begin
      n_err++; $display("FAIL retry pulses err=%0d done=%0d want 1 0", nerr, ndone);
    end
  endtask

  task automatic test_reset_mid_tx();
    tx_data = 8'h3B; tx_valid = 1'b1;
    tick();
    tx_valid = 1'b0;
    repeat (56) tick();  // mid bit 3 (d2=0), so the line is being driven
    n_vec++;
    if (io_drive_low !== 1'b1) begin n_err++; $display("FAIL midrst pre_drive got=%b want=1", io_drive_low); end
    rstnin = 1'b0;
    tick();
    n_vec++;
    if ({io_drive_low, busy, tx_ready, tx_done, tx_err, rx_valid, rx_parity_err} !== 7'b0) begin
      n_err++;
      $display("FAIL midrst outs got=%b want=0000000",
               {io_drive_low, busy, tx_ready, tx_done, tx_err, rx_valid, rx_parity_err});
    end
    n_vec++;
    if (rx_data !== 8'h00) begin n_err++; $display("FAIL midrst rx_data got=%h want=00", rx_data); end
    tick();
    rstnin = 1'b1;
    tick();
    test_tx_3b("tx3b_after_reset");
  endtask

  initial begin
    test_reset();
    test_tx_3b("tx3b");
    repeat (5) tick();
    test_rx(8'hA5, 1'b0, "rx_a5_good");
    repeat (5) tick();
    test_rx(8'hA5, 1'b1, "rx_a5_bad");
    repeat (5) tick();
    test_glitch();
    test_retry();
    repeat (5) tick();
    test_reset_mid_tx();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
